// File: rtl/serial_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : serial_mac_acc
// Purpose  : Bit-serial multiply-accumulate. Computes sum_k a_k*b_k (unsigned
//            or two's-complement) one multiplier bit per clock, optionally
//            adding onto the previous result, and holds the result behind a
//            ready/out_ack handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   valid       in   operation request, accepted when valid && in_ready
//   in_ready    out  high only while idle
//   a, b        in   SIZE*SETS operands, set k at [k*SIZE +: SIZE]
//   is_signed   in   1 = two's-complement operands (sampled on accept)
//   accumulate  in   1 = add onto current accumulator (sampled on accept)
//   clear       in   zero accumulator and overflow (idle only)
//   ready       out  result valid, held until out_ack
//   out_ack     in   consumer takes the result
//   out         out  OUT_W-bit result register
//   overflow    out  sticky accumulator overflow flag
// ============================================================================
module serial_mac_acc #(
    parameter int SIZE  = 4,
    parameter int SETS  = 1,
    parameter int GUARD = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 valid,
    output logic                                 in_ready,
    input  logic [SIZE*SETS-1:0]                 a,
    input  logic [SIZE*SETS-1:0]                 b,
    input  logic                                 is_signed,
    input  logic                                 accumulate,
    input  logic                                 clear,
    output logic                                 ready,
    input  logic                                 out_ack,
    output logic [2*SIZE+$clog2(SETS)+GUARD-1:0] out,
    output logic                                 overflow
);

    localparam int OUT_W = 2*SIZE + $clog2(SETS) + GUARD;
    localparam int BIT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SIZE - 1);
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    // r_a is shifted down by SIZE per completed set so the active a_k is
    // always in the low bits; r_b is shifted by one per step so the active
    // multiplier bit is always r_b[0] (packing order equals step order).
    logic [SIZE*SETS-1:0] r_a;
    logic [SIZE*SETS-1:0] r_b;
    logic                 r_signed;
    logic [OUT_W-1:0]     r_acc;
    logic [BIT_W-1:0]     r_bit_idx;
    logic [SET_W-1:0]     r_set_idx;

    logic                 w_last_bit;
    logic                 w_last_step;
    logic                 w_sub;
    logic                 w_ovf;
    logic [OUT_W-1:0]     w_a_ext;
    logic [OUT_W-1:0]     w_term;
    logic [OUT_W-1:0]     w_sum;
    logic [OUT_W:0]       w_sum_ext;

    assign in_ready    = (r_state == IDLE);
    assign w_last_bit  = (r_bit_idx == LAST_BIT);
    assign w_last_step = w_last_bit && (r_set_idx == LAST_SET);

    // One shift-add step plus mode-dependent range check of the true sum.
    always_comb begin
        w_a_ext   = r_signed ? {{(OUT_W-SIZE){r_a[SIZE-1]}}, r_a[SIZE-1:0]}
                             : {{(OUT_W-SIZE){1'b0}}, r_a[SIZE-1:0]};
        w_term    = w_a_ext << r_bit_idx;
        // The signed multiplier MSB carries negative weight.
        w_sub     = r_signed && w_last_bit;
        w_sum_ext = w_sub ? ({1'b0, r_acc} - {1'b0, w_term})
                          : ({1'b0, r_acc} + {1'b0, w_term});
        w_sum     = w_sum_ext[OUT_W-1:0];
        if (r_signed) begin
            if (w_sub) begin
                w_ovf = (r_acc[OUT_W-1] != w_term[OUT_W-1]) &&
                        (w_sum[OUT_W-1] != r_acc[OUT_W-1]);
            end else begin
                w_ovf = (r_acc[OUT_W-1] == w_term[OUT_W-1]) &&
                        (w_sum[OUT_W-1] != r_acc[OUT_W-1]);
            end
        end else begin
            w_ovf = w_sum_ext[OUT_W];
        end
        if (!r_b[0]) begin
            w_sum = r_acc;
            w_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (valid)       w_state_next = MUL;
            MUL:     if (w_last_step) w_state_next = DONE;
            DONE:    if (out_ack)     w_state_next = IDLE;
            default:                  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_acc     <= '0;
            r_bit_idx <= '0;
            r_set_idx <= '0;
            out       <= '0;
            ready     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_signed  <= is_signed;
                        r_bit_idx <= '0;
                        r_set_idx <= '0;
                        // clear together with valid behaves as a fresh start.
                        if (!accumulate || clear) begin
                            r_acc    <= '0;
                            overflow <= 1'b0;
                        end
                    end else if (clear) begin
                        r_acc    <= '0;
                        overflow <= 1'b0;
                    end
                end
                MUL: begin
                    r_acc <= w_sum;
                    if (w_ovf) begin
                        overflow <= 1'b1;
                    end
                    r_b <= r_b >> 1;
                    if (w_last_bit) begin
                        r_bit_idx <= '0;
                        r_set_idx <= r_set_idx + 1'b1;
                        r_a       <= r_a >> SIZE;
                    end else begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                    if (w_last_step) begin
                        out   <= w_sum;
                        ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ack) begin
                        ready <= 1'b0;
                    end
                end
                default: begin
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_mac_acc
// Purpose  : Scoreboard bench for serial_mac_acc. Two instances:
//            dut0 SIZE=4 SETS=4 GUARD=4 (OUT_W=14), dut1 SIZE=4 SETS=1
//            GUARD=0 (OUT_W=8). Expected results come from an integer
//            reference model and are popped by a monitor on ready.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_mac_acc;

    typedef struct {
        logic [63:0] out;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        valid0, in_ready0, is_signed0, accumulate0, clear0;
    logic        ready0, out_ack0, overflow0;
    logic [15:0] a0, b0;
    logic [13:0] out0;

    logic        valid1, in_ready1, is_signed1, accumulate1, clear1;
    logic        ready1, out_ack1, overflow1;
    logic [3:0]  a1, b1;
    logic [7:0]  out1;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    longint      m_acc [2];
    logic        m_ovf [2];
    exp_t        last_exp [2];
    int          acc_edge [2];
    logic        rdy_q [2];

    serial_mac_acc #(.SIZE(4), .SETS(4), .GUARD(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .valid(valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .is_signed(is_signed0), .accumulate(accumulate0),
        .clear(clear0), .ready(ready0), .out_ack(out_ack0), .out(out0),
        .overflow(overflow0)
    );

    serial_mac_acc #(.SIZE(4), .SETS(1), .GUARD(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .valid(valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .is_signed(is_signed1), .accumulate(accumulate1),
        .clear(clear1), .ready(ready1), .out_ack(out_ack1), .out(out1),
        .overflow(overflow1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic get_ready(input int d);
        return (d == 0) ? ready0 : ready1;
    endfunction
    function automatic logic get_in_ready(input int d);
        return (d == 0) ? in_ready0 : in_ready1;
    endfunction
    function automatic logic get_valid(input int d);
        return (d == 0) ? valid0 : valid1;
    endfunction
    function automatic logic [63:0] get_out(input int d);
        return (d == 0) ? 64'(out0) : 64'(out1);
    endfunction
    function automatic logic get_ovf(input int d);
        return (d == 0) ? overflow0 : overflow1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the multiplier bits in order, treating the stored
    // accumulator as a number in the current operation's mode.
    task automatic model_op(input int d, input logic [15:0] av, input logic [15:0] bv,
                            input bit sgn, input bit accu);
        int     w    = (d == 0) ? 14 : 8;
        int     sets = (d == 0) ? 4 : 1;
        longint modv;
        longint cur, t, ak, term;
        modv = longint'(1) << w;
        if (!accu) begin
            m_acc[d] = 0;
            m_ovf[d] = 1'b0;
        end
        for (int k = 0; k < sets; k++) begin
            ak = longint'((av >> (4*k)) & 16'hF);
            if (sgn && ak >= 8) ak -= 16;
            for (int j = 0; j < 4; j++) begin
                if (bv[4*k+j]) begin
                    term = ak * (longint'(1) << j);
                    if (sgn && j == 3) term = -term;
                    cur = m_acc[d];
                    if (sgn && cur >= modv/2) cur -= modv;
                    t = cur + term;
                    if (sgn ? (t < -(modv/2) || t >= modv/2) : (t < 0 || t >= modv))
                        m_ovf[d] = 1'b1;
                    m_acc[d] = ((t % modv) + modv) % modv;
                end
            end
        end
    endtask

    task automatic monitor(input int d);
        exp_t e;
        int   lat;
        if (reset_n) begin
            if (get_valid(d) && get_in_ready(d)) acc_edge[d] = cyc + 1;
            if (get_ready(d) && !rdy_q[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d unexpected result: got out %0d expected no result", d, get_out(d));
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    lat = cyc - acc_edge[d];
                    check($sformatf("dut%0d out", d), get_out(d), e.out);
                    check($sformatf("dut%0d overflow", d), 64'(get_ovf(d)), 64'(e.ovf));
                    check($sformatf("dut%0d latency", d), 64'(lat), (d == 0) ? 64'd16 : 64'd4);
                end
            end
        end
        rdy_q[d] = get_ready(d);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) monitor(d);
    end

    task automatic set_in(input int d, input logic v, input logic [15:0] av, input logic [15:0] bv,
                          input logic sgn, input logic accu, input logic clr);
        if (d == 0) begin
            valid0 = v; a0 = av; b0 = bv; is_signed0 = sgn; accumulate0 = accu; clear0 = clr;
        end else begin
            valid1 = v; a1 = av[3:0]; b1 = bv[3:0]; is_signed1 = sgn; accumulate1 = accu; clear1 = clr;
        end
    endtask

    task automatic set_ack(input int d, input logic v);
        if (d == 0) out_ack0 = v;
        else        out_ack1 = v;
    endtask

    task automatic clear_idle(input int d);
        set_in(d, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_in(d, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        m_acc[d] = 0;
        m_ovf[d] = 1'b0;
    endtask

    // want_out/want_ovf < 0 means take the model's value.
    task automatic run_op(input int d, input logic [15:0] av, input logic [15:0] bv,
                          input bit sgn, input bit accu, input bit clr, input int hold,
                          input bit bp, input int want_out, input int want_ovf);
        exp_t e;
        int   n;
        model_op(d, av, bv, sgn, accu && !clr);
        e.out = (want_out >= 0) ? 64'(want_out) : 64'(m_acc[d]);
        e.ovf = (want_ovf >= 0) ? (want_ovf != 0) : m_ovf[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        last_exp[d] = e;
        set_in(d, 1'b1, av, bv, sgn, accu, clr);
        @(posedge clk); #1;
        set_in(d, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (get_ready(d) !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (get_ready(d) !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL dut%0d ready timeout: got ready 0 expected 1 within 200 cycles", d);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            if (bp && d == 0) begin
                set_in(0, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom));
            end
            @(posedge clk); #1;
            if (bp && d == 0) begin
                check("bp out stable", 64'(out0), last_exp[0].out);
                check("bp in_ready", 64'(in_ready0), 64'd0);
                check("bp ready held", 64'(ready0), 64'd1);
            end
        end
        set_in(d, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        set_ack(d, 1'b1);
        @(posedge clk); #1;
        set_ack(d, 1'b0);
        if (bp) begin
            check("ack ready low", 64'(get_ready(d)), 64'd0);
            check("ack in_ready high", 64'(get_in_ready(d)), 64'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        set_in(0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        set_in(1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        out_ack0 = 1'b0;
        out_ack1 = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0; m_ovf[d] = 1'b0; acc_edge[d] = 0; rdy_q[d] = 1'b0;
        end
        #2;
        check("reset in_ready0", 64'(in_ready0), 64'd1);
        check("reset ready0", 64'(ready0), 64'd0);
        check("reset out0", 64'(out0), 64'd0);
        check("reset overflow0", 64'(overflow0), 64'd0);
        check("reset in_ready1", 64'(in_ready1), 64'd1);
        check("reset ready1", 64'(ready1), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Small unsigned product, then accumulate / clear sequence.
        run_op(1, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2, 0);
        run_op(1, 16'd1, 16'd3, 1'b0, 1'b1, 1'b0, 1, 1'b0, 5, 0);
        clear_idle(1);
        run_op(1, 16'd1, 16'd1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1, 0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0) clear_idle(1);
            run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 2), 1'b0, -1, -1);
        end

        // Overflow with no guard bits.
        run_op(1, 16'd15, 16'd15, 1'b0, 1'b0, 1'b0, 0, 1'b0, 225, 0);
        run_op(1, 16'd15, 16'd15, 1'b0, 1'b1, 1'b0, 0, 1'b0, 194, 1);

        // Four-set operations.
        run_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0, 1'b0, 900, 0);
        run_op(0, 16'h8F21, 16'h8821, 1'b1, 1'b0, 1'b0, 0, 1'b0, 77, 0);
        run_op(0, 16'h8F21, 16'h8821, 1'b0, 1'b0, 1'b0, 0, 1'b0, 189, 0);
        run_op(0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
        run_op(0, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b0, 10, 1'b1, -1, -1);
        run_op(0, 16'h00F0, 16'h0F0F, 1'b0, 1'b1, 1'b1, 0, 1'b0, -1, -1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) clear_idle(0);
            run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 2),
                   ($urandom_range(0, 9) == 0), -1, -1);
        end

        // Asynchronous reset in the middle of a multiply.
        set_in(1, 1'b1, 16'd15, 16'd15, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        set_in(1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("midreset ready1", 64'(ready1), 64'd0);
        check("midreset in_ready1", 64'(in_ready1), 64'd1);
        check("midreset out1", 64'(out1), 64'd0);
        check("midreset overflow1", 64'(overflow1), 64'd0);
        check("midreset out0", 64'(out0), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0; m_ovf[d] = 1'b0;
        end
        @(posedge clk); #1;
        run_op(1, 16'd3, 16'd5, 1'b0, 1'b1, 1'b0, 0, 1'b0, 15, 0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard0 drained", 64'(q0.size()), 64'd0);
        check("scoreboard1 drained", 64'(q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
